// File: rtl/em_drv_pkg.sv
// rtl/em_drv_pkg.sv - shared states, bridge drive codes and counter sizing for the magnet driver
package em_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    HOLD,
    DEAD_A,
    DEGAUSS,
    DEAD_B
  } em_state_t;

  localparam logic [1:0] EM_OFF = 2'b00;
  localparam logic [1:0] EM_FWD = 2'b01;
  localparam logic [1:0] EM_REV = 2'b10;

  // One width for the phase and pwm counters: wide enough for the longest phase
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/em_channel.sv
// rtl/em_channel.sv - one magnet channel: kick, pwm hold, dead-timed degauss on release
module em_channel
  import em_drv_pkg::*;
#(
  parameter int KICK_CYC    = 50000,
  parameter int PWM_PERIOD  = 100,
  parameter int HOLD_DUTY   = 40,
  parameter int DEAD_CYC    = 10,
  parameter int DEGAUSS_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pick,
  output logic [1:0] emo,
  output logic       held,
  output logic       busy
);

  localparam int CW = cnt_width(KICK_CYC, DEGAUSS_CYC, DEAD_CYC, PWM_PERIOD);
  localparam logic [CW-1:0] KICK_LAST = CW'(KICK_CYC - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);
  localparam logic [CW-1:0] DEG_LAST  = CW'(DEGAUSS_CYC - 1);
  localparam logic [CW-1:0] PWM_LAST  = CW'(PWM_PERIOD - 1);
  localparam logic [CW-1:0] DUTY      = CW'(HOLD_DUTY);

  em_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] pwm_cnt, pwm_n;
  logic [1:0]    emo_n;
  logic          held_n, busy_n;

  // State, counters and the registered bridge drive; reset drops the bridge to 00 at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pwm_cnt <= '0;
      emo     <= EM_OFF;
      held    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pwm_cnt <= pwm_n;
      emo     <= emo_n;
      held    <= held_n;
      busy    <= busy_n;
    end
  end

  // Next state and drive; only KICK/HOLD respond to pick, the release sequence always runs out
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pwm_n   = pwm_cnt;
    emo_n   = EM_OFF;
    held_n  = 1'b0;
    busy_n  = (state != IDLE);
    case (state)
      IDLE: begin
        if (pick) begin
          state_n = KICK;
          cnt_n   = '0;
        end
      end
      KICK: begin
        emo_n = EM_FWD;
        if (!pick) begin
          state_n = DEAD_A;
          cnt_n   = '0;
        end else if (cnt == KICK_LAST) begin
          state_n = HOLD;
          cnt_n   = '0;
          pwm_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HOLD: begin
        emo_n  = (pwm_cnt < DUTY) ? EM_FWD : EM_OFF;
        held_n = 1'b1;
        pwm_n  = (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + CW'(1);
        if (!pick) begin
          state_n = DEAD_A;
          cnt_n   = '0;
        end
      end
      DEAD_A: begin
        if (cnt == DEAD_LAST) begin
          state_n = DEGAUSS;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DEGAUSS: begin
        emo_n = EM_REV;
        if (cnt == DEG_LAST) begin
          state_n = DEAD_B;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DEAD_B: begin
        if (cnt == DEAD_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/em_multi_driver.sv
// rtl/em_multi_driver.sv - N independent electromagnet channels onto the H-bridge pins
module em_multi_driver
  import em_drv_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int KICK_CYC    = 50000,
  parameter int PWM_PERIOD  = 100,
  parameter int HOLD_DUTY   = 40,
  parameter int DEAD_CYC    = 10,
  parameter int DEGAUSS_CYC = 5000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   pick,
  output logic [2*N_CH-1:0] emo,
  output logic [N_CH-1:0]   held,
  output logic [N_CH-1:0]   busy
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    em_channel #(
      .KICK_CYC    (KICK_CYC),
      .PWM_PERIOD  (PWM_PERIOD),
      .HOLD_DUTY   (HOLD_DUTY),
      .DEAD_CYC    (DEAD_CYC),
      .DEGAUSS_CYC (DEGAUSS_CYC)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .pick  (pick[i]),
      .emo   (emo[2*i+1:2*i]),
      .held  (held[i]),
      .busy  (busy[i])
    );
  end

endmodule

// File: tb/tb_em_multi_driver.sv
// tb/tb_em_multi_driver.sv - scoreboard bench for em_multi_driver at duty 2, 0 and 4
module tb_em_multi_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] pick_a, pick_e;
  logic [3:0] emo_a, emo_z, emo_f;
  logic [1:0] held_a, busy_a, held_z, busy_z, held_f, busy_f;

  typedef struct {
    logic [3:0] emo;
    logic [1:0] held;
    logic [1:0] busy;
    logic [1:0] ez;
    logic [1:0] ef;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  em_multi_driver #(.N_CH(2), .KICK_CYC(4), .PWM_PERIOD(4), .HOLD_DUTY(2), .DEAD_CYC(2), .DEGAUSS_CYC(3))
    dut_a (.clk(clk), .rst_n(rst_n), .pick(pick_a), .emo(emo_a), .held(held_a), .busy(busy_a));
  em_multi_driver #(.N_CH(2), .KICK_CYC(4), .PWM_PERIOD(4), .HOLD_DUTY(0), .DEAD_CYC(2), .DEGAUSS_CYC(3))
    dut_z (.clk(clk), .rst_n(rst_n), .pick(pick_e), .emo(emo_z), .held(held_z), .busy(busy_z));
  em_multi_driver #(.N_CH(2), .KICK_CYC(4), .PWM_PERIOD(4), .HOLD_DUTY(4), .DEAD_CYC(2), .DEGAUSS_CYC(3))
    dut_f (.clk(clk), .rst_n(rst_n), .pick(pick_e), .emo(emo_f), .held(held_f), .busy(busy_f));

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // Monitor: pops one expected entry per cycle and compares away from the active edge
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic bad;
      e = q.pop_front();
      chk("emo_a", emo_a, e.emo);
      chk("held_a", {2'b00, held_a}, {2'b00, e.held});
      chk("busy_a", {2'b00, busy_a}, {2'b00, e.busy});
      chk("emo_duty0", emo_z, {2'b00, e.ez});
      chk("emo_duty4", emo_f, {2'b00, e.ef});
      bad = (emo_a[1:0] == 2'b11) || (emo_a[3:2] == 2'b11) ||
            (emo_z[1:0] == 2'b11) || (emo_f[1:0] == 2'b11);
      chk("pair_11", {3'b000, bad}, 4'b0000);
    end
  end

  // Drive one cycle of pick and queue the outputs expected in that same cycle
  task automatic step(input logic [1:0] p, input logic [1:0] e0, input logic [1:0] e1,
                      input logic [1:0] h, input logic [1:0] b,
                      input logic [1:0] ez, input logic [1:0] ef);
    exp_t e;
    pick_a = p;
    pick_e = {1'b0, p[0]};
    e.emo  = {e1, e0};
    e.held = h;
    e.busy = b;
    e.ez   = ez;
    e.ef   = ef;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] hp(input int k);
    return ((k % 4) < 2) ? 2'b01 : 2'b00;
  endfunction

  // ch0 release as seen on the pins: 00 x2, 10 x3, 00 x2, busy throughout
  task automatic drop_tail(input logic [1:0] p_dead, input logic [1:0] p_rest);
    repeat (2) step(p_dead, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    repeat (3) step(p_rest, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10);
    repeat (2) step(p_rest, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
  endtask

  logic [1:0] e1_tab [16] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                              2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
  logic       p1_tab [16] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  logic       h1_tab [16] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  logic       b1_tab [16] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    int k;
    rst_n  = 1'b0;
    pick_a = 2'b00;
    pick_e = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_emo_a", emo_a, 4'b0000);
    chk("reset_held_a", {2'b00, held_a}, 4'b0000);
    chk("reset_busy_a", {2'b00, busy_a}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // idle after release
    repeat (3) step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // pick ch0: two cycles of latency, 4 kick cycles, then hold pattern
    repeat (2) step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    repeat (4) step(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01);
    k = 0;
    repeat (8) begin
      step(2'b01, hp(k), 2'b00, 2'b01, 2'b01, 2'b00, 2'b01);
      k++;
    end

    // ch1 picks then drops while ch0 keeps its hold pattern
    for (int d = 0; d < 16; d++) begin
      step({p1_tab[d], 1'b1}, hp(k), e1_tab[d], {h1_tab[d], 1'b1}, {b1_tab[d], 1'b1}, 2'b00, 2'b01);
      k++;
    end

    // drop ch0 from hold
    repeat (2) begin
      step(2'b00, hp(k), 2'b00, 2'b01, 2'b01, 2'b00, 2'b01);
      k++;
    end
    drop_tail(2'b00, 2'b00);
    repeat (2) step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // abort after two kick cycles
    repeat (2) step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    repeat (2) step(2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01);
    drop_tail(2'b00, 2'b00);
    repeat (2) step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // re-pick during degauss: release completes, one idle cycle, then kick
    step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    step(2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01);
    drop_tail(2'b00, 2'b01);
    step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    repeat (4) step(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01);
    for (int j = 0; j < 4; j++) step(2'b01, hp(j), 2'b00, 2'b01, 2'b01, 2'b00, 2'b01);

    // asynchronous reset while ch0 holds: outputs clear with no clock edge
    rst_n  = 1'b0;
    pick_a = 2'b00;
    pick_e = 2'b00;
    #2;
    chk("midreset_emo_a", emo_a, 4'b0000);
    chk("midreset_held_a", {2'b00, held_a}, 4'b0000);
    chk("midreset_busy_a", {2'b00, busy_a}, 4'b0000);
    chk("midreset_emo_f", emo_f, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    repeat (2) step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    repeat (2) step(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01);

    chk("queue_drain", 4'(q.size()), 4'b0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
